// File: rtl/data_sramlike_bridge_pkg.sv
// rtl/data_sramlike_bridge_pkg.sv - shared types and constants for the sram-like data bridge
// Purpose: bridge FSM state encoding, access size codes and a store-detect helper.
// Ports:   none (package).
package data_sramlike_bridge_pkg;

   // Access size codes carried on mem_size / data_size
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_WAIT_DATA = 2'b01,
      ST_DONE      = 2'b10,
      ST_DRAIN     = 2'b11
   } bridge_state_t;

   // Any byte-write strobe set makes the access a store
   function automatic logic is_store(input logic [3:0] sel);
      return |sel;
   endfunction

endpackage

// File: rtl/data_sramlike_bridge_if.sv
// rtl/data_sramlike_bridge_if.sv - sram-like data bus between the bridge and the cache/AXI side
// Purpose: groups the single-outstanding req/addr_ok/data_ok transaction signals.
// Signals: req, wr, size, addr, wdata (master -> slave); rdata, addr_ok, data_ok (slave -> master).
interface data_sramlike_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              wr;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              addr_ok;
   logic              data_ok;

   modport master (
      output req, wr, size, addr, wdata,
      input  rdata, addr_ok, data_ok
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output rdata, addr_ok, data_ok
   );
endinterface

// File: rtl/data_sramlike_bridge.sv
// rtl/data_sramlike_bridge.sv - M-stage load/store to sram-like bus transaction bridge
// Purpose: issues one sram-like transaction per M-stage access, stalls the pipeline until it
//          completes, holds the returned word for load extraction, and drains (never aborts) an
//          outstanding transaction when the access is cancelled by an exception/flush.
// Ports:   clk, resetn          clock, synchronous active-low reset
//          i_mem_en/sel/size/addr/wdata   M-stage access request
//          i_mem_cancel         exception/flush in M, suppresses issue
//          i_pipe_stall         pipeline held by another source
//          o_mem_rdata          registered load word, valid in DONE
//          o_mem_stall          hold pipeline at M and earlier
//          bus                  sram-like master port
module data_sramlike_bridge
   import data_sramlike_bridge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        i_mem_en,
   input  logic [3:0]                  i_mem_sel,
   input  logic [1:0]                  i_mem_size,
   input  logic [ADDR_W-1:0]           i_mem_addr,
   input  logic [DATA_W-1:0]           i_mem_wdata,
   input  logic                        i_mem_cancel,
   input  logic                        i_pipe_stall,
   output logic [DATA_W-1:0]           o_mem_rdata,
   output logic                        o_mem_stall,
   data_sramlike_bridge_if.master      bus
);

   bridge_state_t     r_state;
   bridge_state_t     w_next;
   logic [DATA_W-1:0] r_rdata;
   logic              w_go;
   logic              w_capture;

   assign w_go = i_mem_en & ~i_mem_cancel;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (w_capture) begin
            r_rdata <= bus.rdata;
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // data_ok is ignored here: nothing can be outstanding in IDLE
            if (w_go && bus.addr_ok) begin
               w_next = ST_WAIT_DATA;
            end
         end
         ST_WAIT_DATA: begin
            if (bus.data_ok) begin
               if (i_mem_cancel) begin
                  w_next = ST_IDLE;
               end else begin
                  w_next    = ST_DONE;
                  w_capture = 1'b1;
               end
            end else if (i_mem_cancel) begin
               // Transaction still in flight: wait it out before anything new may issue
               w_next = ST_DRAIN;
            end
         end
         ST_DONE: begin
            if (i_mem_cancel || !i_pipe_stall) begin
               w_next = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (bus.data_ok) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Request only from IDLE; address/data pass straight through since M is stalled while req=1
   assign bus.req   = (r_state == ST_IDLE) & w_go;
   assign bus.wr    = is_store(i_mem_sel);
   assign bus.size  = i_mem_size;
   assign bus.addr  = i_mem_addr;
   assign bus.wdata = i_mem_wdata;

   // go already folds in cancel, so a cancelled access never stalls
   assign o_mem_stall = w_go & (r_state != ST_DONE);
   assign o_mem_rdata = r_rdata;

endmodule
